// File: rtl/dm_access_ctrl.sv
// Arbitrates MEM-stage and debug accesses onto one data-memory bus; grant registers dm_* one edge later.
// Holds each access until dm_ready or TIMEOUT; the CPU side is back-pressured through pipe_stall.
module dm_access_ctrl #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_DM_read,
    input  logic              mem_DM_write,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_sw_o,
    output logic [DATA_W-1:0] mem_load_data,
    output logic              pipe_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [DATA_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic              dm_cs,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ready,
    output logic              bus_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, CPU_ACC, DBG_ACC} state_t;

    state_t            state_q;
    logic [SW-1:0]     starve_q;
    logic [TW-1:0]     tmo_q;
    logic              cs_q, we_q, dbg_done_q, bus_err_q, cpu_abort_q;
    logic [DATA_W-1:0] addr_q, wdata_q, dbg_rdata_q, hold_q;

    logic cpu_req, cpu_ok, dbg_ok, grant_dbg, grant_cpu, cpu_done, tmo_hit;

    // A CPU request seen in its own abort cycle, or a debug request seen in
    // its own done cycle, is the stale tail of the access that just ended.
    assign cpu_req   = mem_DM_read | mem_DM_write;
    assign cpu_ok    = cpu_req & ~cpu_abort_q;
    assign dbg_ok    = dbg_req & ~dbg_done_q;
    assign grant_dbg = (state_q == IDLE) & dbg_ok &
                       (~cpu_ok | (starve_q >= SW'(STARVE_MAX)));
    assign grant_cpu = (state_q == IDLE) & cpu_ok & ~grant_dbg;
    assign cpu_done  = (state_q == CPU_ACC) & dm_ready;
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));

    assign pipe_stall    = cpu_req & ~cpu_done & ~cpu_abort_q;
    assign mem_load_data = cpu_done ? dm_rdata : hold_q;
    assign dbg_rdata     = dbg_rdata_q;
    assign dbg_done      = dbg_done_q;
    assign dm_cs         = cs_q;
    assign dm_we         = we_q;
    assign dm_addr       = addr_q;
    assign dm_wdata      = wdata_q;
    assign bus_err       = bus_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            dbg_done_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            cpu_abort_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dbg_rdata_q <= '0;
            hold_q      <= '0;
        end else begin
            dbg_done_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            cpu_abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_dbg) begin
                        state_q  <= DBG_ACC;
                        cs_q     <= 1'b1;
                        we_q     <= dbg_we;
                        addr_q   <= dbg_addr;
                        wdata_q  <= dbg_wdata;
                        starve_q <= '0;
                        tmo_q    <= '0;
                    end else if (grant_cpu) begin
                        state_q  <= CPU_ACC;
                        cs_q     <= 1'b1;
                        we_q     <= mem_DM_write;
                        addr_q   <= mem_alu_result;
                        wdata_q  <= mem_sw_o;
                        tmo_q    <= '0;
                        if (dbg_ok && (starve_q < SW'(STARVE_MAX)))
                            starve_q <= starve_q + 1'b1;
                    end
                end
                CPU_ACC, DBG_ACC: begin
                    if (dm_ready) begin
                        state_q <= IDLE;
                        cs_q    <= 1'b0;
                        if (state_q == CPU_ACC) begin
                            if (!we_q) hold_q <= dm_rdata;
                        end else begin
                            if (!we_q) dbg_rdata_q <= dm_rdata;
                            dbg_done_q <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state_q   <= IDLE;
                        cs_q      <= 1'b0;
                        bus_err_q <= 1'b1;
                        if (state_q == CPU_ACC) cpu_abort_q <= 1'b1;
                        else                    dbg_done_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of bus ownership.
module tb_dm_access_ctrl;

    localparam int STARVE = 4;
    localparam int TMO    = 16;

    logic        clk, rst;
    logic        rd, wr, dreq, dwe, rdy;
    logic [31:0] addr, sw, daddr, dwd, rdata;
    logic [31:0] mem_load_data, dbg_rdata, dm_addr, dm_wdata;
    logic        pipe_stall, dbg_done, dm_cs, dm_we, bus_err;

    dm_access_ctrl #(.DATA_W(32), .STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_DM_read(rd), .mem_DM_write(wr), .mem_alu_result(addr), .mem_sw_o(sw),
        .mem_load_data(mem_load_data), .pipe_stall(pipe_stall),
        .dbg_req(dreq), .dbg_we(dwe), .dbg_addr(daddr), .dbg_wdata(dwd),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .dm_cs(dm_cs), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(rdata), .dm_ready(rdy), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus, how many cs cycles it has had, plus registered outputs.
    int          owner;   // 0 nobody, 1 cpu, 2 debug
    int          age;
    int          starve;
    bit          m_cs, m_we, m_done, m_err, m_abort;
    logic [31:0] m_addr, m_wdata, m_hold, m_drdata;
    bit          last_adv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; age = 0; starve = 0;
        m_cs = 0; m_we = 0; m_done = 0; m_err = 0; m_abort = 0;
        m_addr = '0; m_wdata = '0; m_hold = '0; m_drdata = '0;
    endtask

    task automatic model_update();
        bit cpu_ok, dbg_ok, was_done, was_abort;
        was_done  = m_done;
        was_abort = m_abort;
        m_done = 0; m_err = 0; m_abort = 0;
        if (owner == 0) begin
            cpu_ok = (rd | wr) && !was_abort;
            dbg_ok = dreq && !was_done;
            if (dbg_ok && (!cpu_ok || starve >= STARVE)) begin
                owner = 2; age = 0; starve = 0;
                m_cs = 1; m_we = dwe; m_addr = daddr; m_wdata = dwd;
            end else if (cpu_ok) begin
                owner = 1; age = 0;
                m_cs = 1; m_we = wr; m_addr = addr; m_wdata = sw;
                if (dbg_ok && starve < STARVE) starve = starve + 1;
            end
        end else if (rdy) begin
            if (owner == 1 && !m_we) m_hold = rdata;
            if (owner == 2) begin
                if (!m_we) m_drdata = rdata;
                m_done = 1;
            end
            owner = 0; m_cs = 0;
        end else if (age == TMO - 1) begin
            m_err = 1;
            if (owner == 1) m_abort = 1; else m_done = 1;
            owner = 0; m_cs = 0;
        end else begin
            age = age + 1;
        end
    endtask

    // Called at a negedge after inputs are driven: compare every output with the model.
    task automatic settle();
        bit          exp_stall;
        logic [31:0] exp_load;
        #1;
        exp_stall = (rd | wr) && !(owner == 1 && rdy) && !m_abort;
        exp_load  = (owner == 1 && rdy) ? rdata : m_hold;
        last_adv  = !exp_stall;
        chk("dm_cs", dm_cs, m_cs);
        chk("dm_we", dm_we, m_we);
        chk("dm_addr", dm_addr, m_addr);
        chk("dm_wdata", dm_wdata, m_wdata);
        chk("dbg_rdata", dbg_rdata, m_drdata);
        chk("dbg_done", dbg_done, m_done);
        chk("bus_err", bus_err, m_err);
        chk("pipe_stall", pipe_stall, exp_stall);
        chk("mem_load_data", mem_load_data, exp_load);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_reset(); else model_update();
        @(negedge clk);
    endtask

    task automatic quiesce(input int n);
        rd = 0; wr = 0; dreq = 0; rdy = 1;
        for (int i = 0; i < n; i++) begin settle(); advance(); end
    endtask

    initial begin
        int n_cs, n_stall, cpu_before, dbg_grants, dones, errs, dead;
        bit prev_cs, seen, drop_next;

        rst = 1; rd = 0; wr = 0; dreq = 0; dwe = 0; rdy = 0;
        addr = '0; sw = '0; daddr = '0; dwd = '0; rdata = '0;
        model_reset();
        @(negedge clk);
        settle();
        chk("reset_cs", dm_cs, 0);
        chk("reset_load", mem_load_data, 0);
        chk("reset_dbg_rdata", dbg_rdata, 0);
        advance();
        rst = 0;

        // CPU load 0x100, ready in first cs cycle.
        rd = 1; addr = 32'h100; rdy = 0;
        settle();
        chk("t1_stall_idle", pipe_stall, 1);
        advance();
        rdy = 1; rdata = 32'hDEADBEEF;
        settle();
        chk("t1_cs", dm_cs, 1);
        chk("t1_we", dm_we, 0);
        chk("t1_addr", dm_addr, 32'h100);
        chk("t1_stall_done", pipe_stall, 0);
        chk("t1_load_now", mem_load_data, 32'hDEADBEEF);
        advance();
        rd = 0; rdy = 0; rdata = 32'h0;
        settle();
        chk("t1_cs_low", dm_cs, 0);
        chk("t1_load_held", mem_load_data, 32'hDEADBEEF);
        chk("t1_model_hold", m_hold, 32'hDEADBEEF);
        advance();

        // CPU store 0x104, ready after three wait cycles.
        wr = 1; addr = 32'h104; sw = 32'h12345678; rdy = 0; rdata = 32'h11111111;
        n_stall = 0; n_cs = 0;
        settle();
        n_stall += pipe_stall;
        advance();
        for (int i = 0; i < 4; i++) begin
            rdy = (i == 3);
            settle();
            n_stall += pipe_stall;
            n_cs += dm_cs;
            chk("t2_we", dm_we, 1);
            chk("t2_wdata", dm_wdata, 32'h12345678);
            advance();
        end
        chk("t2_stall_cycles", n_stall, 4);
        chk("t2_cs_cycles", n_cs, 4);
        wr = 0; rdy = 0;
        settle();
        chk("t2_hold_unchanged", mem_load_data, 32'hDEADBEEF);
        advance();

        // Debug starved by continuous CPU loads, memory always ready.
        rd = 1; addr = 32'h400; dreq = 1; dwe = 0; daddr = 32'h300; rdy = 1;
        rdata = 32'h55AA0001;
        prev_cs = 0; cpu_before = 0; dbg_grants = 0; dones = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_done) dreq = 0;
            settle();
            if (dm_cs && !prev_cs) begin
                if (dm_addr == 32'h300) dbg_grants++;
                else if (dbg_grants == 0) cpu_before++;
            end
            prev_cs = dm_cs;
            dones += dbg_done;
            advance();
        end
        chk("t3_cpu_grants", cpu_before, STARVE);
        chk("t3_dbg_grants", dbg_grants, 1);
        chk("t3_dbg_done", dones, 1);
        chk("t3_model_starve", starve, 0);
        quiesce(3);

        // Debug read 0x200, no CPU traffic.
        dreq = 1; dwe = 0; daddr = 32'h200; rdy = 0;
        settle();
        chk("t4_stall_idle", pipe_stall, 0);
        advance();
        rdy = 1; rdata = 32'hCAFEF00D;
        settle();
        chk("t4_cs", dm_cs, 1);
        chk("t4_addr", dm_addr, 32'h200);
        advance();
        rdy = 0; rdata = 32'h0;
        settle();
        chk("t4_done", dbg_done, 1);
        chk("t4_rdata", dbg_rdata, 32'hCAFEF00D);
        dreq = 0;
        advance();
        settle();
        chk("t4_done_once", dbg_done, 0);
        chk("t4_rdata_held", dbg_rdata, 32'hCAFEF00D);
        advance();

        // CPU load that never sees dm_ready.
        rd = 1; addr = 32'h108; rdy = 0; rdata = 32'h0BADBAD0;
        n_cs = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            settle();
            if (dm_cs) n_cs++;
            else if (n_cs > 0) begin
                seen = 1;
                chk("t5_bus_err", bus_err, 1);
                chk("t5_stall_drop", pipe_stall, 0);
                chk("t5_load_unchanged", mem_load_data, 32'h55AA0001);
            end
            advance();
        end
        chk("t5_abort_seen", seen, 1);
        chk("t5_cs_cycles", n_cs, TMO);
        rd = 0;
        settle();
        chk("t5_err_once", bus_err, 0);
        chk("t5_no_regrant", dm_cs, 0);
        advance();

        // Reset in the middle of a CPU access.
        rd = 1; addr = 32'h10C; rdy = 0;
        settle(); advance();
        settle();
        chk("t6_cs_before", dm_cs, 1);
        rst = 1; rd = 0;
        model_reset();
        settle();
        chk("t6_cs", dm_cs, 0);
        chk("t6_addr", dm_addr, 0);
        chk("t6_stall", pipe_stall, 0);
        chk("t6_load", mem_load_data, 0);
        advance();
        rst = 0;
        dones = 0; errs = 0;
        for (int i = 0; i < 20; i++) begin
            rdy = $urandom_range(0, 1);
            rdata = $urandom;
            settle();
            dones += dbg_done;
            errs += bus_err;
            advance();
        end
        chk("t6_no_done", dones, 0);
        chk("t6_no_err", errs, 0);

        // Random traffic from both masters against a randomly stalling memory.
        rd = 0; wr = 0; dreq = 0; last_adv = 1; dead = 0; drop_next = 0;
        for (int i = 0; i < 1500; i++) begin
            if (last_adv) begin
                case ($urandom_range(0, 3))
                    0: begin rd = 0; wr = 0; end
                    1: begin rd = 1; wr = 0; end
                    2: begin rd = 0; wr = 1; end
                    default: begin rd = 1; wr = 1; end
                endcase
                addr = $urandom; sw = $urandom;
            end
            if (drop_next) begin
                dreq = 0; drop_next = 0;
            end else if (dreq && m_done) begin
                if ($urandom_range(0, 1) == 1) dreq = 0; else drop_next = 1;
            end else if (!dreq && $urandom_range(0, 3) == 0) begin
                dreq = 1; dwe = $urandom_range(0, 1); daddr = $urandom; dwd = $urandom;
            end
            if (dead > 0) begin
                rdy = 0; dead--;
            end else begin
                if ($urandom_range(0, 149) == 0) dead = 20;
                rdy = ($urandom_range(0, 99) < 35);
            end
            rdata = $urandom;
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
